// File: rtl/alu_op_sequencer.sv
// ALU decode/execute stage: single-cycle ops plus iterative unsigned multiply and divide.
// Optional macro ALU_SEQ_DIV_EN compiles in the divider; without it funct 0x1a decodes as illegal.
module alu_op_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic              zero,
  output logic              illegal,
  output logic              busy
);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLL, OP_SRL, OP_MUL, OP_DIV, OP_ILL
  } op_t;

  state_t            r_state, w_state_next;
  op_t               w_op;
  logic [SH_W-1:0]   r_cnt;
  logic [DATA_W-1:0] r_hi, r_lo, r_b;
  logic              r_ill;
  logic              w_accept, w_last, w_multi;
  logic [DATA_W-1:0] w_single, w_step_hi, w_step_lo;
  logic [DATA_W:0]   w_mul_sum;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == SH_W'(DATA_W - 1));
  assign w_multi  = (w_op == OP_MUL) || (w_op == OP_DIV);

  // alu_op[0] (sub) takes priority over alu_op[1] (funct decode)
  always_comb begin
    w_op = OP_ADD;
    if (alu_op[0]) begin
      w_op = OP_SUB;
    end else if (alu_op[1]) begin
      case (funct)
        6'h20:   w_op = OP_ADD;
        6'h22:   w_op = OP_SUB;
        6'h24:   w_op = OP_AND;
        6'h25:   w_op = OP_OR;
        6'h26:   w_op = OP_XOR;
        6'h27:   w_op = OP_NOR;
        6'h2a:   w_op = OP_SLT;
        6'h00:   w_op = OP_SLL;
        6'h02:   w_op = OP_SRL;
        6'h18:   w_op = OP_MUL;
`ifdef ALU_SEQ_DIV_EN
        6'h1a:   w_op = OP_DIV;
`endif
        default: w_op = OP_ILL;
      endcase
    end
  end

  always_comb begin
    w_single = '0;
    case (w_op)
      OP_ADD:  w_single = op_a + op_b;
      OP_SUB:  w_single = op_a - op_b;
      OP_AND:  w_single = op_a & op_b;
      OP_OR:   w_single = op_a | op_b;
      OP_XOR:  w_single = op_a ^ op_b;
      OP_NOR:  w_single = ~(op_a | op_b);
      OP_SLT:  w_single = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL:  w_single = op_a << op_b[SH_W-1:0];
      OP_SRL:  w_single = op_a >> op_b[SH_W-1:0];
      default: w_single = '0;
    endcase
  end

  // Shift-add multiply: {r_hi, r_lo} holds {partial product, remaining multiplier}
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
  logic              r_div;
  logic [DATA_W:0]   w_div_sh;
  logic              w_div_ge;
  logic [DATA_W-1:0] w_div_diff;

  // Restoring divide: r_hi is the remainder, r_lo shifts dividend out and quotient in.
  // A zero divisor naturally yields an all-ones quotient and remainder = dividend.
  assign w_div_sh   = {r_hi, r_lo[DATA_W-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
  assign w_div_diff = w_div_sh[DATA_W-1:0] - r_b;

  always_comb begin
    w_step_hi = w_mul_sum[DATA_W:1];
    w_step_lo = {w_mul_sum[0], r_lo[DATA_W-1:1]};
    if (r_div) begin
      w_step_hi = w_div_ge ? w_div_diff : w_div_sh[DATA_W-1:0];
      w_step_lo = {r_lo[DATA_W-2:0], w_div_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 1'b0;
    end else if (w_accept) begin
      r_div <= (w_op == OP_DIV);
    end
  end
`else
  assign w_step_hi = w_mul_sum[DATA_W:1];
  assign w_step_lo = {w_mul_sum[0], r_lo[DATA_W-1:1]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_multi ? S_CALC : S_DONE;
      S_CALC:  if (w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_ill <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_b   <= op_b;
            r_ill <= (w_op == OP_ILL);
            r_hi  <= '0;
            r_lo  <= w_multi ? op_a : w_single;
          end
        end
        S_CALC: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
        end
        default: ;
      endcase
    end
  end

  // Outputs read as reset values whenever no result is being presented
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = out_valid ? r_lo : '0;
  assign result_hi = out_valid ? r_hi : '0;
  assign illegal   = out_valid && r_ill;
  assign zero      = (result == '0);
endmodule
